// File: rtl/m_load_rsp_if.sv
// Bundle of the request, memory-bus and response handshakes used by m_load_rsp.
// The slave modport is the load-response block itself; master is its environment.
interface m_load_rsp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_deop;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_exc;
   logic        rsp_timeout;

   modport slave (
      input  req_valid, req_addr, req_deop, mem_rvalid, mem_rdata, rsp_ready,
      output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_exc, rsp_timeout
   );

   modport master (
      output req_valid, req_addr, req_deop, mem_rvalid, mem_rdata, rsp_ready,
      input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_exc, rsp_timeout
   );
endinterface

// File: rtl/m_load_rsp.sv
// M-stage load response unit: accepts one load at a time, issues a single
// word read, then aligns and sign/zero-extends the returned data. Misaligned
// or illegal loads raise an address-error flag without touching the bus; a bus
// that stays silent for TIMEOUT_CYCLES WAIT cycles ends the load with a timeout.
module m_load_rsp #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic          clk,
   input logic          reset,
   m_load_rsp_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] DEOP_LW  = 3'd0;
   localparam logic [2:0] DEOP_LH  = 3'd1;
   localparam logic [2:0] DEOP_LHU = 3'd2;
   localparam logic [2:0] DEOP_LB  = 3'd3;
   localparam logic [2:0] DEOP_LBU = 3'd4;

   // Last counter value before the load is abandoned (counter starts at 0).
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

   // True when the load type is legal and the address meets its alignment.
   function automatic logic load_ok(input logic [2:0] deop, input logic [1:0] lo);
      logic ok;
      case (deop)
         DEOP_LW:           ok = (lo == 2'b00);
         DEOP_LH, DEOP_LHU: ok = (lo[0] == 1'b0);
         DEOP_LB, DEOP_LBU: ok = 1'b1;
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Selects the addressed half/byte from the raw word and extends it.
   function automatic logic [31:0] extract(input logic [2:0]  deop,
                                           input logic [1:0]  lo,
                                           input logic [31:0] word);
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      logic [31:0] res;
      half_v = lo[1] ? word[31:16] : word[15:0];
      case (lo)
         2'b00:   byte_v = word[7:0];
         2'b01:   byte_v = word[15:8];
         2'b10:   byte_v = word[23:16];
         2'b11:   byte_v = word[31:24];
         default: byte_v = 8'h00;
      endcase
      case (deop)
         DEOP_LW:  res = word;
         DEOP_LH:  res = {{16{half_v[15]}}, half_v};
         DEOP_LHU: res = {16'h0000, half_v};
         DEOP_LB:  res = {{24{byte_v[7]}}, byte_v};
         DEOP_LBU: res = {24'h00_0000, byte_v};
         default:  res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   state_t      state_r;
   logic [2:0]  deop_r;
   logic [1:0]  addr_lo_r;
   logic [7:0]  cnt_r;
   logic        req_ready_r;
   logic        mem_re_r;
   logic [31:0] mem_addr_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_data_r;
   logic        rsp_exc_r;
   logic        rsp_timeout_r;

   // Load FSM: owns every piece of state and every registered output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         deop_r        <= 3'd0;
         addr_lo_r     <= 2'd0;
         cnt_r         <= 8'd0;
         req_ready_r   <= 1'b1;
         mem_re_r      <= 1'b0;
         mem_addr_r    <= 32'h0000_0000;
         rsp_valid_r   <= 1'b0;
         rsp_data_r    <= 32'h0000_0000;
         rsp_exc_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid && req_ready_r) begin
                  deop_r      <= bus.req_deop;
                  addr_lo_r   <= bus.req_addr[1:0];
                  req_ready_r <= 1'b0;
                  if (load_ok(bus.req_deop, bus.req_addr[1:0])) begin
                     mem_re_r   <= 1'b1;
                     mem_addr_r <= {bus.req_addr[31:2], 2'b00};
                     cnt_r      <= 8'd0;
                     state_r    <= ST_WAIT;
                  end else begin
                     // Address error: answer directly, the bus is never touched.
                     rsp_valid_r   <= 1'b1;
                     rsp_data_r    <= 32'h0000_0000;
                     rsp_exc_r     <= 1'b1;
                     rsp_timeout_r <= 1'b0;
                     state_r       <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               mem_re_r <= 1'b0;
               // Returned data beats the timeout when both land in one cycle.
               if (bus.mem_rvalid) begin
                  rsp_valid_r   <= 1'b1;
                  rsp_data_r    <= extract(deop_r, addr_lo_r, bus.mem_rdata);
                  rsp_exc_r     <= 1'b0;
                  rsp_timeout_r <= 1'b0;
                  state_r       <= ST_RESP;
               end else if (cnt_r == CNT_LAST) begin
                  rsp_valid_r   <= 1'b1;
                  rsp_data_r    <= 32'h0000_0000;
                  rsp_exc_r     <= 1'b0;
                  rsp_timeout_r <= 1'b1;
                  state_r       <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_RESP: begin
               // Result is held untouched until the consumer takes it.
               if (bus.rsp_ready) begin
                  rsp_valid_r   <= 1'b0;
                  rsp_data_r    <= 32'h0000_0000;
                  rsp_exc_r     <= 1'b0;
                  rsp_timeout_r <= 1'b0;
                  req_ready_r   <= 1'b1;
                  state_r       <= ST_IDLE;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               req_ready_r   <= 1'b1;
               mem_re_r      <= 1'b0;
               rsp_valid_r   <= 1'b0;
               rsp_data_r    <= 32'h0000_0000;
               rsp_exc_r     <= 1'b0;
               rsp_timeout_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.mem_re      = mem_re_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_data    = rsp_data_r;
   assign bus.rsp_exc     = rsp_exc_r;
   assign bus.rsp_timeout = rsp_timeout_r;

endmodule
